// File: rtl/accel_spi_pkg.sv
// accel_spi_pkg: opcodes, register addresses, FSM states and helpers for the accelerometer SPI responder
package accel_spi_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    localparam logic [7:0] ADDR_DEVID_AD   = 8'h00;
    localparam logic [7:0] ADDR_DEVID_MST  = 8'h01;
    localparam logic [7:0] ADDR_PARTID     = 8'h02;
    localparam logic [7:0] ADDR_X_HI8      = 8'h08;
    localparam logic [7:0] ADDR_Y_HI8      = 8'h09;
    localparam logic [7:0] ADDR_Z_HI8      = 8'h0A;
    localparam logic [7:0] ADDR_X_L        = 8'h0E;
    localparam logic [7:0] ADDR_X_H        = 8'h0F;
    localparam logic [7:0] ADDR_Y_L        = 8'h10;
    localparam logic [7:0] ADDR_Y_H        = 8'h11;
    localparam logic [7:0] ADDR_Z_L        = 8'h12;
    localparam logic [7:0] ADDR_Z_H        = 8'h13;
    localparam logic [7:0] ADDR_SOFT_RESET = 8'h1F;
    localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;
    localparam logic [7:0] ADDR_SELF_TEST  = 8'h2E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_IGNORE
    } state_e;

    // Two's-complement 12-bit add clamped to -2048..2047
    function automatic logic [11:0] sat_add12(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {a[11], a} + {b[11], b};
        return (s[12] != s[11]) ? (s[12] ? 12'h800 : 12'h7FF) : s[11:0];
    endfunction

    // Upper byte of a right-justified sample: sign nibble plus bits 11:8
    function automatic logic [7:0] hi_sext(input logic [11:0] v);
        return {{4{v[11]}}, v[11:8]};
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronizes sclk/ss/mosi into the system clock and derives edge strobes
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic ss_i,
    input  logic mosi_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic ss_fall_o,
    output logic ss_rise_o,
    output logic mosi_o
);

    logic [STAGES-1:0] sclk_sync_q;
    logic [STAGES-1:0] ss_sync_q;
    logic [STAGES-1:0] mosi_sync_q;
    logic              sclk_prev_q;
    logic              ss_prev_q;
    logic              sclk_s;
    logic              ss_s;

    // Synchronizer chains plus one delayed copy of sclk/ss for edge detection; ss idles high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[STAGES-2:0], sclk_i};
            ss_sync_q   <= {ss_sync_q[STAGES-2:0], ss_i};
            mosi_sync_q <= {mosi_sync_q[STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_sync_q[STAGES-1];
            ss_prev_q   <= ss_sync_q[STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_q[STAGES-1];
    assign ss_s        = ss_sync_q[STAGES-1];
    assign mosi_o      = mosi_sync_q[STAGES-1];
    assign sclk_rise_o = sclk_s & ~sclk_prev_q & ~ss_s;
    assign sclk_fall_o = ~sclk_s & sclk_prev_q & ~ss_s;
    assign ss_fall_o   = ss_prev_q & ~ss_s;
    assign ss_rise_o   = ~ss_prev_q & ss_s;

endmodule

// File: rtl/accel_spi_responder.sv
// accel_spi_responder: SPI mode-0 responder modelling the accelerometer register map (self-test register under ACCEL_SELFTEST_EN)
module accel_spi_responder
    import accel_spi_pkg::*;
#(
    parameter logic [7:0]        DEVID_AD        = 8'hAD,
    parameter logic [7:0]        DEVID_MST       = 8'h1D,
    parameter logic [7:0]        PARTID          = 8'hF2,
    parameter int                SYNC_STAGES     = 2,
    parameter logic signed [11:0] SELFTEST_OFFSET = 12'sd64
) (
    input  logic        clock,
    input  logic        anti_reset,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [11:0] accel_x_in,
    input  logic [11:0] accel_y_in,
    input  logic [11:0] accel_z_in,
    output logic [7:0]  power_ctl,
    output logic        soft_reset_pulse,
    output logic        busy,
    output logic        cmd_error
);

    logic        sclk_rise;
    logic        sclk_fall;
    logic        ss_fall;
    logic        ss_rise;
    logic        mosi_s;
    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  addr_q, addr_d;
    logic        read_q, read_d;
    logic        miso_q, miso_d;
    logic [7:0]  power_ctl_q, power_ctl_d;
    logic        soft_reset_q, soft_reset_d;
    logic        cmd_error_q, cmd_error_d;
    logic [11:0] snap_x_q, snap_x_d;
    logic [11:0] snap_y_q, snap_y_d;
    logic [11:0] snap_z_q, snap_z_d;
    logic [7:0]  rx_byte;
    logic [7:0]  fetch_addr;
    logic [7:0]  rd_data;
    logic [11:0] x_rep;
    logic        selftest_on;
`ifdef ACCEL_SELFTEST_EN
    logic [7:0]  selftest_q, selftest_d;
`endif

    spi_pin_sync #(
        .STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clk_i      (clock),
        .rst_ni     (anti_reset),
        .sclk_i     (sclk),
        .ss_i       (ss),
        .mosi_i     (mosi),
        .sclk_rise_o(sclk_rise),
        .sclk_fall_o(sclk_fall),
        .ss_fall_o  (ss_fall),
        .ss_rise_o  (ss_rise),
        .mosi_o     (mosi_s)
    );

`ifdef ACCEL_SELFTEST_EN
    assign selftest_on = selftest_q[0];
`else
    assign selftest_on = 1'b0;
`endif

    assign x_rep      = selftest_on ? sat_add12(snap_x_q, SELFTEST_OFFSET) : snap_x_q;
    assign rx_byte    = {rx_q[6:0], mosi_s};
    assign fetch_addr = (state_q == ST_ADDR) ? rx_byte : addr_q + 8'd1;

    // Register read mux; the address comes straight from the shifter when the address byte completes
    always_comb begin
        rd_data = 8'h00;
        case (fetch_addr)
            ADDR_DEVID_AD:  rd_data = DEVID_AD;
            ADDR_DEVID_MST: rd_data = DEVID_MST;
            ADDR_PARTID:    rd_data = PARTID;
            ADDR_X_HI8:     rd_data = x_rep[11:4];
            ADDR_Y_HI8:     rd_data = snap_y_q[11:4];
            ADDR_Z_HI8:     rd_data = snap_z_q[11:4];
            ADDR_X_L:       rd_data = x_rep[7:0];
            ADDR_X_H:       rd_data = hi_sext(x_rep);
            ADDR_Y_L:       rd_data = snap_y_q[7:0];
            ADDR_Y_H:       rd_data = hi_sext(snap_y_q);
            ADDR_Z_L:       rd_data = snap_z_q[7:0];
            ADDR_Z_H:       rd_data = hi_sext(snap_z_q);
            ADDR_POWER_CTL: rd_data = power_ctl_q;
`ifdef ACCEL_SELFTEST_EN
            ADDR_SELF_TEST: rd_data = selftest_q;
`endif
            default:        rd_data = 8'h00;
        endcase
    end

    // Next state: ss edges frame a transaction, rise strobes shift in and finish bytes, fall strobes shift out
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        read_d       = read_q;
        miso_d       = miso_q;
        power_ctl_d  = power_ctl_q;
        soft_reset_d = 1'b0;
        cmd_error_d  = cmd_error_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        snap_z_d     = snap_z_q;
`ifdef ACCEL_SELFTEST_EN
        selftest_d   = selftest_q;
`endif
        if (ss_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else if (ss_fall) begin
            state_d     = ST_CMD;
            bit_cnt_d   = 3'd0;
            cmd_error_d = 1'b0;
            miso_d      = 1'b0;
        end else if (sclk_rise && state_q != ST_IDLE) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    ST_CMD: begin
                        if (rx_byte == CMD_READ) begin
                            state_d  = ST_ADDR;
                            read_d   = 1'b1;
                            snap_x_d = accel_x_in;
                            snap_y_d = accel_y_in;
                            snap_z_d = accel_z_in;
                        end else if (rx_byte == CMD_WRITE) begin
                            state_d = ST_ADDR;
                            read_d  = 1'b0;
                        end else begin
                            state_d     = ST_IGNORE;
                            cmd_error_d = 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        addr_d  = rx_byte;
                        state_d = read_q ? ST_RD : ST_WR;
                        tx_d    = read_q ? rd_data : tx_q;
                    end
                    ST_RD: begin
                        addr_d = addr_q + 8'd1;
                        tx_d   = rd_data;
                    end
                    ST_WR: begin
                        addr_d = addr_q + 8'd1;
                        if (addr_q == ADDR_POWER_CTL)
                            power_ctl_d = rx_byte;
`ifdef ACCEL_SELFTEST_EN
                        if (addr_q == ADDR_SELF_TEST)
                            selftest_d = rx_byte;
`endif
                        if (addr_q == ADDR_SOFT_RESET && rx_byte == SOFT_RESET_KEY) begin
                            power_ctl_d  = 8'h00;
                            soft_reset_d = 1'b1;
`ifdef ACCEL_SELFTEST_EN
                            selftest_d   = 8'h00;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end else if (sclk_fall && state_q == ST_RD) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 8'h00;
            tx_q         <= 8'h00;
            addr_q       <= 8'h00;
            read_q       <= 1'b0;
            miso_q       <= 1'b0;
            power_ctl_q  <= 8'h00;
            soft_reset_q <= 1'b0;
            cmd_error_q  <= 1'b0;
            snap_x_q     <= 12'h000;
            snap_y_q     <= 12'h000;
            snap_z_q     <= 12'h000;
`ifdef ACCEL_SELFTEST_EN
            selftest_q   <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            read_q       <= read_d;
            miso_q       <= miso_d;
            power_ctl_q  <= power_ctl_d;
            soft_reset_q <= soft_reset_d;
            cmd_error_q  <= cmd_error_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            snap_z_q     <= snap_z_d;
`ifdef ACCEL_SELFTEST_EN
            selftest_q   <= selftest_d;
`endif
        end
    end

    assign miso             = miso_q;
    assign busy             = (state_q != ST_IDLE);
    assign miso_oe          = busy;
    assign power_ctl        = power_ctl_q;
    assign soft_reset_pulse = soft_reset_q;
    assign cmd_error        = cmd_error_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// tb_accel_spi_responder: directed SPI master transactions against the accelerometer responder
module tb_accel_spi_responder;

    logic        clock = 1'b0;
    logic        anti_reset;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [11:0] accel_x_in;
    logic [11:0] accel_y_in;
    logic [11:0] accel_z_in;
    logic [7:0]  power_ctl;
    logic        soft_reset_pulse;
    logic        busy;
    logic        cmd_error;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulse_total = 0;
    int          pulse_base;
    logic [7:0]  r;

    accel_spi_responder dut (
        .clock           (clock),
        .anti_reset      (anti_reset),
        .sclk            (sclk),
        .ss              (ss),
        .mosi            (mosi),
        .miso            (miso),
        .miso_oe         (miso_oe),
        .accel_x_in      (accel_x_in),
        .accel_y_in      (accel_y_in),
        .accel_z_in      (accel_z_in),
        .power_ctl       (power_ctl),
        .soft_reset_pulse(soft_reset_pulse),
        .busy            (busy),
        .cmd_error       (cmd_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (soft_reset_pulse === 1'b1) pulse_total <= pulse_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_start();
        @(negedge clock);
        ss = 1'b0;
        #80;
    endtask

    task automatic spi_byte(input logic [7:0] d, output logic [7:0] q);
        for (int i = 7; i >= 0; i--) begin
            mosi = d[i];
            #40;
            sclk = 1'b1;
            q[i] = miso;
            #40;
            sclk = 1'b0;
        end
    endtask

    task automatic spi_stop();
        #40;
        ss = 1'b1;
        #80;
    endtask

    task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] q;
        spi_start();
        spi_byte(8'h0A, q);
        spi_byte(a, q);
        spi_byte(d, q);
        spi_stop();
    endtask

    initial begin
        anti_reset = 1'b0;
        sclk = 1'b0;
        ss = 1'b1;
        mosi = 1'b0;
        accel_x_in = 12'h321;
        accel_y_in = 12'h000;
        accel_z_in = 12'h9AB;
        #3;
        check("rst_miso", miso, 1'b0);
        check("rst_miso_oe", miso_oe, 1'b0);
        check("rst_power_ctl", power_ctl, 8'h00);
        check("rst_soft_reset", soft_reset_pulse, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_error", cmd_error, 1'b0);
        #19;
        anti_reset = 1'b1;
        #50;

        spi_start();
        check("burst_oe_active", miso_oe, 1'b1);
        check("burst_busy_active", busy, 1'b1);
        spi_byte(8'h0B, r);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r); check("burst_b0", r, 8'hAD);
        spi_byte(8'h00, r); check("burst_b1", r, 8'h1D);
        spi_byte(8'h00, r); check("burst_b2", r, 8'hF2);
        spi_stop();
        check("burst_oe_idle", miso_oe, 1'b0);

        spi_write(8'h2D, 8'h02);
        check("wr_power_ctl", power_ctl, 8'h02);
        spi_start();
        spi_byte(8'h0B, r);
        spi_byte(8'h2D, r);
        spi_byte(8'h00, r); check("rd_power_ctl", r, 8'h02);
        spi_stop();

        spi_write(8'h02, 8'hFF);
        spi_start();
        spi_byte(8'h0B, r);
        spi_byte(8'h02, r);
        spi_byte(8'h00, r); check("ro_partid", r, 8'hF2);
        spi_stop();

        accel_x_in = 12'hFFB;
        accel_y_in = 12'h123;
        spi_start();
        spi_byte(8'h0B, r);
        spi_byte(8'h0E, r);
        spi_byte(8'h00, r); check("snap_x_l", r, 8'hFB);
        accel_x_in = 12'h7FF;
        accel_y_in = 12'h456;
        spi_byte(8'h00, r); check("snap_x_h", r, 8'hFF);
        spi_byte(8'h00, r); check("snap_y_l", r, 8'h23);
        spi_byte(8'h00, r); check("snap_y_h", r, 8'h01);
        spi_stop();

        spi_start();
        spi_byte(8'h0B, r);
        spi_byte(8'h12, r);
        spi_byte(8'h00, r); check("z_l", r, 8'hAB);
        spi_byte(8'h00, r); check("z_h", r, 8'hF9);
        spi_stop();
        spi_start();
        spi_byte(8'h0B, r);
        spi_byte(8'h08, r);
        spi_byte(8'h00, r); check("x_hi8", r, 8'h7F);
        spi_byte(8'h00, r); check("y_hi8", r, 8'h45);
        spi_byte(8'h00, r); check("z_hi8", r, 8'h9A);
        spi_stop();

        spi_start();
        spi_byte(8'h0A, r);
        spi_byte(8'h2D, r);
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            #40;
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
        end
        #40;
        check("partial_busy_before", busy, 1'b1);
        ss = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("partial_busy_fall", busy, 1'b0);
        #80;
        check("partial_power_ctl", power_ctl, 8'h02);

        spi_start();
        spi_byte(8'h55, r);
        check("bad_cmd_error", cmd_error, 1'b1);
        spi_byte(8'hFF, r); check("bad_cmd_rx", r, 8'h00);
        check("bad_cmd_miso", miso, 1'b0);
        spi_stop();
        check("bad_cmd_sticky", cmd_error, 1'b1);
        spi_start();
        check("cmd_error_clear", cmd_error, 1'b0);
        spi_byte(8'h0B, r);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r); check("after_bad_read", r, 8'hAD);
        spi_stop();

        pulse_base = pulse_total;
        spi_write(8'h1F, 8'h11);
        check("soft_wrong_key_pulses", pulse_total - pulse_base, 0);
        check("soft_wrong_key_power", power_ctl, 8'h02);
        pulse_base = pulse_total;
        spi_write(8'h1F, 8'h52);
        check("soft_reset_pulses", pulse_total - pulse_base, 1);
        check("soft_reset_power", power_ctl, 8'h00);

        spi_start();
        spi_byte(8'h0B, r);
        spi_byte(8'hFF, r);
        spi_byte(8'h00, r); check("wrap_ff", r, 8'h00);
        spi_byte(8'h00, r); check("wrap_00", r, 8'hAD);
        spi_stop();

        spi_write(8'h2D, 8'h07);
        check("pre_reset_power", power_ctl, 8'h07);
        spi_start();
        spi_byte(8'h0B, r);
        #13;
        anti_reset = 1'b0;
        #3;
        check("midrst_busy", busy, 1'b0);
        check("midrst_miso_oe", miso_oe, 1'b0);
        check("midrst_power_ctl", power_ctl, 8'h00);
        ss = 1'b1;
        #24;
        anti_reset = 1'b1;
        #60;
        check("post_rst_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
